mode_s_reply_encoder: RTL and testbench

Transmit side of the Mode S transponder. When the reply controller decides to answer an interrogation, it hands this block a reply frame. The block serialises the frame into the Mode S downlink pulse waveform: an 8 us preamble, then 56 or 112 bits of pulse-position modulation at 1 Mbit/s. The output tx_pulse drives the RF modulator key directly.

---
 rtl/mode_s_pkg.sv | 25 ++
 rtl/mode_s_crc24.sv | 37 +++
 rtl/mode_s_reply_encoder.sv | 177 +++++++++++++++++
 tb/tb_mode_s_reply_encoder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mode_s_pkg.sv
// Shared constants, FSM state type and frame-length helper for the Mode S reply encoder.
package mode_s_pkg;

  localparam int          PREAMBLE_CHIPS   = 16;
  localparam logic [15:0] PREAMBLE_PATTERN = 16'b1010000101000000;

  localparam int SHORT_BITS  = 56;
  localparam int LONG_BITS   = 112;
  localparam int PARITY_BITS = 24;

  localparam logic [23:0] PARITY_POLY = 24'hFFF409;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_DONE
  } state_e;

  // Index of the last data bit for the selected frame format.
  function automatic logic [6:0] frame_last_bit(input logic long_fmt);
    return long_fmt ? 7'(LONG_BITS - 1) : 7'(SHORT_BITS - 1);
  endfunction

endpackage

// File: rtl/mode_s_crc24.sv
// Serial Mode S 24-bit parity engine: one message bit per shift, MSB first, register starts at 0.
module mode_s_crc24
  import mode_s_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        shift_en_i,
  input  logic        bit_i,
  output logic [23:0] crc_o
);

  logic [23:0] crc_q, crc_d;
  logic        fb;

  assign fb = bit_i ^ crc_q[23];

  always_comb begin
    crc_d = crc_q;
    if (clear_i) begin
      crc_d = '0;
    end else if (shift_en_i) begin
      crc_d = {crc_q[22:0], 1'b0} ^ (fb ? PARITY_POLY : 24'h0);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/mode_s_reply_encoder.sv
// Mode S downlink reply serialiser: 8 us preamble followed by PPM data chips on tx_pulse.
// Define MODE_S_CRC_GEN_EN to replace the last 24 bits with generated parity XOR parity_xor.
module mode_s_reply_encoder
  import mode_s_pkg::*;
#(
  parameter int CHIP_CYCLES = 10
)
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         long_fmt,
  input  logic [111:0] data_in,
  input  logic [23:0]  parity_xor,
  output logic         ready,
  output logic         tx_enable,
  output logic         tx_pulse,
  output logic         done
);

  localparam int            CW        = (CHIP_CYCLES > 1) ? $clog2(CHIP_CYCLES) : 1;
  localparam logic [CW-1:0] CHIP_LAST = CW'(CHIP_CYCLES - 1);
  localparam logic [3:0]    PRE_LAST  = 4'(PREAMBLE_CHIPS - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [3:0]     pre_q, pre_d;
  logic           half_q, half_d;
  logic [6:0]     bit_q, bit_d;
  logic [111:0]   shift_q, shift_d;
  logic           long_q, long_d;
  logic [23:0]    pxor_q, pxor_d;

  logic           accept;
  logic           chip_end;
  logic           last_pre_chip;
  logic           last_bit_chip;
  logic [6:0]     last_bit;
  logic           cur_bit;

  assign accept        = start && ready;
  assign chip_end      = (cyc_q == CHIP_LAST);
  assign last_bit      = frame_last_bit(long_q);
  assign last_pre_chip = chip_end && (pre_q == PRE_LAST);
  // half_q=1 marks the second chip of the current data bit.
  assign last_bit_chip = chip_end && half_q && (bit_q == last_bit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:     if (accept) state_d = ST_PREAMBLE;
      ST_PREAMBLE: if (last_pre_chip) state_d = ST_DATA;
      ST_DATA:     if (last_bit_chip) state_d = ST_DONE;
      ST_DONE:     state_d = accept ? ST_PREAMBLE : ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cyc_d   = cyc_q;
    pre_d   = pre_q;
    half_d  = half_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    long_d  = long_q;
    pxor_d  = pxor_q;
    if (accept) begin
      cyc_d   = '0;
      pre_d   = '0;
      half_d  = 1'b0;
      bit_d   = '0;
      shift_d = data_in;
      long_d  = long_fmt;
      pxor_d  = parity_xor;
    end else if (state_q == ST_PREAMBLE) begin
      cyc_d = chip_end ? '0 : cyc_q + 1'b1;
      if (chip_end) begin
        pre_d = last_pre_chip ? 4'd0 : pre_q + 4'd1;
      end
    end else if (state_q == ST_DATA) begin
      cyc_d = chip_end ? '0 : cyc_q + 1'b1;
      if (chip_end) begin
        half_d = !half_q;
        if (half_q) begin
          shift_d = {shift_q[110:0], 1'b0};
          bit_d   = (bit_q == last_bit) ? 7'd0 : bit_q + 7'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc_q   <= '0;
      pre_q   <= '0;
      half_q  <= 1'b0;
      bit_q   <= '0;
      shift_q <= '0;
      long_q  <= 1'b0;
      pxor_q  <= '0;
    end else begin
      cyc_q   <= cyc_d;
      pre_q   <= pre_d;
      half_q  <= half_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      long_q  <= long_d;
      pxor_q  <= pxor_d;
    end
  end

`ifdef MODE_S_CRC_GEN_EN
  logic [23:0] crc;
  logic [23:0] parity_word;
  logic        in_parity;
  logic        crc_shift;
  logic [4:0]  par_idx;

  assign in_parity   = (bit_q >= (last_bit - 7'(PARITY_BITS - 1)));
  assign crc_shift   = (state_q == ST_DATA) && chip_end && half_q && !in_parity;
  assign par_idx     = 5'(last_bit - bit_q);
  assign parity_word = crc ^ pxor_q;

  mode_s_crc24 u_crc (
    .clk        (clk),
    .reset      (reset),
    .clear_i    (accept),
    .shift_en_i (crc_shift),
    .bit_i      (shift_q[111]),
    .crc_o      (crc)
  );

  // Parity bits go out MSB first; par_idx counts down 23..0 across the tail.
  assign cur_bit = in_parity ? parity_word[par_idx] : shift_q[111];
`else
  logic unused_pxor;

  assign unused_pxor = ^pxor_q;
  assign cur_bit     = shift_q[111];
`endif

  always_comb begin
    ready     = 1'b0;
    tx_enable = 1'b0;
    tx_pulse  = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_PREAMBLE: begin
        tx_enable = 1'b1;
        tx_pulse  = PREAMBLE_PATTERN[~pre_q];
      end
      ST_DATA: begin
        tx_enable = 1'b1;
        tx_pulse  = cur_bit ^ half_q;
      end
      ST_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: begin
        ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mode_s_reply_encoder.sv
// Scoreboard bench for mode_s_reply_encoder: expected chips queued per frame, compared as they are sent.
module tb_mode_s_reply_encoder;

  localparam int CC = 10;
`ifdef MODE_S_CRC_GEN_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         long_fmt;
  logic [111:0] data_in;
  logic [23:0]  parity_xor;
  logic         ready;
  logic         tx_enable;
  logic         tx_pulse;
  logic         done;

  int           checks = 0;
  int           errors = 0;
  bit           expq[$];
  logic [111:0] rx_bits;

  mode_s_reply_encoder #(.CHIP_CYCLES(CC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .long_fmt   (long_fmt),
    .data_in    (data_in),
    .parity_xor (parity_xor),
    .ready      (ready),
    .tx_enable  (tx_enable),
    .tx_pulse   (tx_pulse),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Augmented long division of (message * x^24) by x^24 + 0xFFF409.
  function automatic logic [23:0] ref_parity(input logic [111:0] d, input bit lng);
    int          n   = lng ? 112 : 56;
    logic [24:0] t;
    logic [23:0] rem = '0;
    logic        m;
    for (int i = 0; i < n; i++) begin
      m = (i < n - 24) ? d[111-i] : 1'b0;
      t = {rem, m};
      if (t[24]) t = t ^ 25'h1FFF409;
      rem = t[23:0];
    end
    return rem;
  endfunction

  function automatic void push_frame(input bit lng, input logic [111:0] d, input logic [23:0] px);
    logic [15:0] pat = 16'b1010000101000000;
    int          n   = lng ? 112 : 56;
    logic [23:0] par;
    bit          b;
    par = ref_parity(d, lng) ^ px;
    for (int i = 0; i < 16; i++) expq.push_back(pat[15-i]);
    for (int i = 0; i < n; i++) begin
      b = d[111-i];
      if (CRC_ON && i >= n - 24) b = par[23-(i-(n-24))];
      expq.push_back(b);
      expq.push_back(!b);
    end
  endfunction

  task automatic send(input bit lng, input logic [111:0] d, input logic [23:0] px);
    int w = 0;
    while (ready !== 1'b1 && w < 5000) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready_timeout ready=%b required 1", ready);
    end
    long_fmt   = lng;
    data_in    = d;
    parity_xor = px;
    start      = 1'b1;
    @(posedge clk); #1;
    start      = 1'b0;
    long_fmt   = ~lng;
    data_in    = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    parity_xor = 24'($urandom());
  endtask

  // Entered one cycle after the accepting edge; leaves one cycle after DONE.
  task automatic run_frame(input string name, input int n_chips, input int pulse_at, input bit hold);
    int cyc = 0;
    bit exp_chip;
    bit bad;
    bit first;
    checks++;
    if (tx_enable !== 1'b1 || ready !== 1'b0) begin
      errors++;
      $display("FAIL %s first_chip tx_enable=%b ready=%b required 1 0", name, tx_enable, ready);
    end
    rx_bits = '0;
    for (int c = 0; c < n_chips; c++) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard_empty chip %0d", name, c);
        exp_chip = 1'b0;
      end else begin
        exp_chip = expq.pop_front();
      end
      bad   = 1'b0;
      first = tx_pulse;
      for (int k = 0; k < CC; k++) begin
        if (tx_pulse !== exp_chip || tx_enable !== 1'b1) bad = 1'b1;
        start = hold || (cyc == pulse_at);
        @(posedge clk); #1;
        cyc++;
      end
      if (c >= 16 && ((c - 16) % 2) == 0) rx_bits = {rx_bits[110:0], first};
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s chip %0d tx_pulse=%b tx_enable=%b required %b 1", name, c, first, tx_enable, exp_chip);
      end
    end
    checks++;
    if ({done, ready, tx_enable, tx_pulse} !== 4'b1100) begin
      errors++;
      $display("FAIL %s done_cycle done/ready/tx_enable/tx_pulse=%b required 1100", name,
               {done, ready, tx_enable, tx_pulse});
    end
    @(posedge clk); #1;
    start = 1'b0;
    if (!hold) begin
      checks++;
      if ({done, ready, tx_enable} !== 3'b010) begin
        errors++;
        $display("FAIL %s after_done done/ready/tx_enable=%b required 010", name, {done, ready, tx_enable});
      end
    end
    $display("frame %s chips %0d decoded %h", name, n_chips, rx_bits);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({ready, tx_enable, tx_pulse, done} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_state ready/tx_enable/tx_pulse/done=%b required 1000", {ready, tx_enable, tx_pulse, done});
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ready, tx_enable, tx_pulse, done} !== 4'b1000) begin
      errors++;
      $display("FAIL idle_after_reset ready/tx_enable/tx_pulse/done=%b required 1000", {ready, tx_enable, tx_pulse, done});
    end
    $display("reset idle ready=%b", ready);
  endtask

  task automatic test_preamble();
    push_frame(1'b0, '0, '0);
    send(1'b0, '0, '0);
    run_frame("preamble_zero", 128, -1, 1'b0);
  endtask

  task automatic test_ppm();
    logic [111:0] d = {8'hA5, 104'h0};
    push_frame(1'b0, d, '0);
    send(1'b0, d, '0);
    run_frame("ppm_a5", 128, -1, 1'b0);
    checks++;
    if (rx_bits[55:48] !== 8'hA5) begin
      errors++;
      $display("FAIL ppm_first_byte got %h required a5", rx_bits[55:48]);
    end
  endtask

  task automatic test_parity();
    logic [111:0] d = {88'h8D4840D6202CC371C32CE0, 24'h5A5A5A};
    logic [23:0]  exp0 = CRC_ON ? 24'h576098 : 24'h5A5A5A;
    logic [23:0]  exp1 = CRC_ON ? 24'hA89F67 : 24'h5A5A5A;
    push_frame(1'b1, d, 24'h000000);
    send(1'b1, d, 24'h000000);
    run_frame("parity_xor0", 240, -1, 1'b0);
    checks++;
    if (rx_bits[23:0] !== exp0) begin
      errors++;
      $display("FAIL parity_tail_xor0 got %h required %h", rx_bits[23:0], exp0);
    end
    checks++;
    if (rx_bits[111:24] !== d[111:24]) begin
      errors++;
      $display("FAIL parity_body got %h required %h", rx_bits[111:24], d[111:24]);
    end
    push_frame(1'b1, d, 24'hFFFFFF);
    send(1'b1, d, 24'hFFFFFF);
    run_frame("parity_xorF", 240, -1, 1'b0);
    checks++;
    if (rx_bits[23:0] !== exp1) begin
      errors++;
      $display("FAIL parity_tail_xorF got %h required %h", rx_bits[23:0], exp1);
    end
  endtask

  task automatic test_midframe_start();
    logic [111:0] d = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    push_frame(1'b1, d, 24'h123456);
    send(1'b1, d, 24'h123456);
    run_frame("midframe_start", 240, 1000, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [111:0] a = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    logic [111:0] b = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    push_frame(1'b0, a, 24'h0F0F0F);
    push_frame(1'b1, b, 24'h00FF00);
    send(1'b0, a, 24'h0F0F0F);
    long_fmt   = 1'b1;
    data_in    = b;
    parity_xor = 24'h00FF00;
    run_frame("b2b_first", 128, -1, 1'b1);
    run_frame("b2b_second", 240, -1, 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    logic [111:0] d = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    send(1'b1, {112{1'b1}}, '0);
    repeat ((16 + 40) * CC) @(posedge clk);
    #1;
    checks++;
    if (tx_pulse !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pulse tx_pulse=%b required 1", tx_pulse);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({tx_pulse, tx_enable} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_frame tx_pulse/tx_enable=%b required 00", {tx_pulse, tx_enable});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({ready, tx_enable, done} !== 3'b100) begin
      errors++;
      $display("FAIL after_reset_release ready/tx_enable/done=%b required 100", {ready, tx_enable, done});
    end
    $display("reset mid-frame abandoned");
    push_frame(1'b0, d, 24'hABCDEF);
    send(1'b0, d, 24'hABCDEF);
    run_frame("fresh_after_reset", 128, -1, 1'b0);
  endtask

  initial begin
    start      = 1'b0;
    long_fmt   = 1'b0;
    data_in    = '0;
    parity_xor = '0;
    reset      = 1'b1;
    test_reset();
    test_preamble();
    test_ppm();
    test_parity();
    test_midframe_start();
    test_back_to_back();
    test_reset_mid_frame();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover entries=%0d required 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
